axis_trailer_append: RTL and testbench

//  AXI-Stream stage placed directly downstream of the AXIS register slice (reg_module).

---
 rtl/axis_trailer_append.sv | 106 ++++++++++
 tb/tb_axis_trailer_append.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_trailer_append.sv
// Forwards payload beats, then appends a beat-count trailer and an XOR checksum trailer (last).
// Latency: one cycle from s transfer to m; the output register is also the timing-isolation stage.
// Backpressure: s_ready follows the free output slot in PASS and is low while the trailers are emitted.
module axis_trailer_append #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          m_ready,
    output logic          m_valid,
    output logic          m_last,
    output logic [DW-1:0] m_data,
    output logic          pkt_done
);

    typedef enum logic [1:0] {PASS, CNT, CSUM} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] acc, acc_nxt;
    logic [DW-1:0] m_data_nxt;
    logic          m_valid_nxt;
    logic          m_last_nxt;
    logic          free;
    logic          accept;

    // The output register may be reloaded when it is empty or being drained this cycle.
    assign free    = !m_valid || m_ready;
    assign s_ready = !reset && (state == PASS) && free;
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        m_data_nxt  = m_data;
        m_valid_nxt = m_valid;
        m_last_nxt  = m_last;
        case (state)
            PASS: begin
                if (accept) begin
                    m_data_nxt  = s_data;
                    m_valid_nxt = 1'b1;
                    m_last_nxt  = 1'b0;
                    acc_nxt     = acc ^ s_data;
                    if (cnt != '1) begin
                        cnt_nxt = cnt + CW'(1);
                    end
                    if (s_last) begin
                        state_nxt = CNT;
                    end
                end else if (free) begin
                    m_valid_nxt = 1'b0;
                    m_last_nxt  = 1'b0;
                end
            end
            CNT: begin
                if (free) begin
                    m_data_nxt  = DW'(cnt);
                    m_valid_nxt = 1'b1;
                    m_last_nxt  = 1'b0;
                    state_nxt   = CSUM;
                end
            end
            CSUM: begin
                if (free) begin
                    m_data_nxt  = acc;
                    m_valid_nxt = 1'b1;
                    m_last_nxt  = 1'b1;
                    cnt_nxt     = '0;
                    acc_nxt     = '0;
                    state_nxt   = PASS;
                end
            end
            default: begin
                state_nxt = PASS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PASS;
            cnt      <= '0;
            acc      <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            m_data   <= m_data_nxt;
            m_valid  <= m_valid_nxt;
            m_last   <= m_last_nxt;
            pkt_done <= m_valid && m_ready && m_last;
        end
    end

endmodule

// File: tb/tb_axis_trailer_append.sv
// Bench for axis_trailer_append: two instances (CW=16 and CW=4) share stimulus; expected beats
// are queued per instance as the driver transfers payload and popped when the DUT hands a beat on.
module tb_axis_trailer_append;

    typedef struct packed {
        logic [31:0] w0, w1, w2, w3, fill;
        int          n;
        logic        rnd;
        int          gap;
        logic [31:0] c16, c4, cs;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;
    logic        s_ready, m_valid, m_last, pkt_done;
    logic [31:0] m_data;
    logic        s_ready4, m_valid4, m_last4, pkt_done4;
    logic [31:0] m_data4;

    int    checks = 0;
    int    errors = 0;
    int    rnd_mode = 0;
    beat_t exp16[$];
    beat_t exp4[$];
    vec_t  tbl[7];

    axis_trailer_append #(.DW(32), .CW(16)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_ready(m_ready), .m_valid(m_valid), .m_last(m_last),
        .m_data(m_data), .pkt_done(pkt_done)
    );

    axis_trailer_append #(.DW(32), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready4), .m_ready(m_ready), .m_valid(m_valid4), .m_last(m_last4),
        .m_data(m_data4), .pkt_done(pkt_done4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_ready = (rnd_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] w0, w1, w2, w3, fill,
                                input logic rnd, input int gap, input logic [31:0] c16, c4, cs);
        vec_t v;
        v.n = n; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3; v.fill = fill;
        v.rnd = rnd; v.gap = gap; v.c16 = c16; v.c4 = c4; v.cs = cs;
        return v;
    endfunction

    function automatic logic [31:0] word(input vec_t v, input int i);
        case (i)
            0: return v.w0;
            1: return v.w1;
            2: return v.w2;
            3: return v.w3;
            default: return v.fill;
        endcase
    endfunction

    // Output checker: stability under backpressure, payload order, pkt_done timing.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic        exp_done = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
            exp_done  = 1'b0;
        end else begin
            chk("pkt_done", pkt_done, exp_done);
            chk("pkt_done_cw4", pkt_done4, exp_done);
            exp_done = m_valid && m_ready && m_last;
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (m_valid && m_ready) begin
                if (exp16.size() == 0 || exp4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none at %0t", m_data, $time);
                end else begin
                    beat_t a, b;
                    a = exp16.pop_front();
                    b = exp4.pop_front();
                    chk("m_data", m_data, a.d);
                    chk("m_last", m_last, a.l);
                    chk("valid_cw4", m_valid4, 1);
                    chk("m_data_cw4", m_data4, b.d);
                    chk("m_last_cw4", m_last4, b.l);
                end
            end
        end
    end

    task automatic summary_and_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int budget;
        budget = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL s_ready_timeout actual=0 required=1 at %0t", $time);
                summary_and_stop();
            end
        end
        @(posedge clk);
        #1;
        exp16.push_back('{d: d, l: 1'b0});
        exp4.push_back('{d: d, l: 1'b0});
    endtask

    task automatic send_vec(input vec_t v);
        rnd_mode = int'(v.rnd);
        if (v.gap > 0) begin
            s_valid = 1'b0;
            repeat (v.gap) begin
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < v.n; i++) begin
            send_beat(word(v, i), i == v.n - 1);
        end
        exp16.push_back('{d: v.c16, l: 1'b0});
        exp16.push_back('{d: v.cs, l: 1'b1});
        exp4.push_back('{d: v.c4, l: 1'b0});
        exp4.push_back('{d: v.cs, l: 1'b1});
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp16.size() != 0 || exp4.size() != 0) begin
            @(posedge clk);
            budget++;
            if (budget > 2000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout actual=%0d required=0", exp16.size());
                summary_and_stop();
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_pkt_done"}, pkt_done, 0);
        chk({tag, "_m_valid_cw4"}, m_valid4, 0);
        chk({tag, "_m_data_cw4"}, m_data4, 0);
    endtask

    initial begin
        //                n   w0           w1           w2           w3  fill rnd gap c16 c4  csum
        tbl[0] = mk(3,  1,           2,           4,           0,  0,   0,  0,  3,  3,  7);
        tbl[1] = mk(1,  32'h2A,      0,           0,           0,  0,   0,  2,  1,  1,  32'h2A);
        tbl[2] = mk(4,  10,          20,          30,          40, 0,   1,  1,  4,  4,  32'h28);
        tbl[3] = mk(2,  5,           5,           0,           0,  0,   0,  1,  2,  2,  0);
        tbl[4] = mk(1,  9,           0,           0,           0,  0,   0,  0,  1,  1,  9);
        tbl[5] = mk(20, 1,           1,           1,           1,  1,   0,  0,  20, 15, 0);
        tbl[6] = mk(4,  32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 0, 0, 1,  3,  4,  4,  32'h33661768);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");
        chk("rst_s_ready", s_ready, 0);
        chk("rst_s_ready_cw4", s_ready4, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            send_vec(tbl[i]);
        end
        s_valid = 1'b0;
        wait_drain();

        // Single-beat packet: s_ready stays low while both trailers go out.
        rnd_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_beat(32'h2A, 1'b1);
        s_valid = 1'b0;
        exp16.push_back('{d: 32'd1, l: 1'b0});
        exp16.push_back('{d: 32'h2A, l: 1'b1});
        exp4.push_back('{d: 32'd1, l: 1'b0});
        exp4.push_back('{d: 32'h2A, l: 1'b1});
        @(negedge clk);
        chk("s_ready_cnt", s_ready, 0);
        @(negedge clk);
        chk("s_ready_csum", s_ready, 0);
        @(negedge clk);
        chk("s_ready_pass", s_ready, 1);
        wait_drain();

        // Reset mid-packet: partial packet is dropped, next packet starts clean.
        send_beat(7, 1'b0);
        send_beat(8, 1'b0);
        s_valid = 1'b0;
        reset = 1'b1;
        exp16.delete();
        exp4.delete();
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        reset = 1'b0;
        send_vec(mk(1, 3, 0, 0, 0, 0, 0, 1, 1, 1, 3));
        s_valid = 1'b0;
        wait_drain();

        chk("leftover_cw16", exp16.size(), 0);
        chk("leftover_cw4", exp4.size(), 0);
        summary_and_stop();
    end

endmodule
